// File: rtl/rv_decode_stage_if.sv
// rv_decode_stage_if: instruction-in / decoded-entry-out channel for the decode stage.
//   in_*  : fetch side (in_valid, in_ready, in_insn[31:0], in_pc[63:0])
//   out_* : execute side (out_valid, out_ready, out_pc, out_insn, out_rd/rs1/rs2,
//           out_imm[XLEN-1:0], out_class[3:0], out_op[5:0], out_illegal)
//   master: the producer of instructions / consumer of decoded entries.
//   slave : the decode stage itself.
interface rv_decode_stage_if #(
  parameter int unsigned XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_insn;
  logic [63:0]     in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [63:0]     out_pc;
  logic [31:0]     out_insn;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [XLEN-1:0] out_imm;
  logic [3:0]      out_class;
  logic [5:0]      out_op;
  logic            out_illegal;

  modport master (
    output in_valid, in_insn, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_insn, out_rd, out_rs1, out_rs2,
           out_imm, out_class, out_op, out_illegal
  );

  modport slave (
    input  in_valid, in_insn, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_insn, out_rd, out_rs1, out_rs2,
           out_imm, out_class, out_op, out_illegal
  );
endinterface

// File: rtl/rv_decode_stage.sv
// rv_decode_stage: RV32IM/RV64IM instruction decode with an output FIFO.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : synchronous flush; empties the FIFO, drops the offered input
//   bus (slave)  : in_* handshake from fetch, out_* FIFO head to execute
//   cnt_decoded  : accepted instructions (wraps)
//   cnt_illegal  : accepted illegal instructions (saturates at 0xFFFF)
// Parameters: XLEN (32 or 64), DEPTH (power of 2, >= 2).
// Macro DECODE_RVM_EN: when defined, M-extension encodings decode as legal.
module rv_decode_stage #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  rv_decode_stage_if.slave  bus,
  output logic [31:0]       cnt_decoded,
  output logic [15:0]       cnt_illegal
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam bit          RV32 = (XLEN == 32);

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic [63:0]     pc;
    logic [31:0]     insn;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [3:0]      cls;
    logic [5:0]      op;
    logic            illegal;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, empty, push, pop;

  // Immediate formats, all sign-extended unless noted.
  logic [31:0]     insn;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_z;
  logic            f7_m, op_f7_ok, shift_ok, is_w, ill;
  logic [3:0]      cls;
  entry_t          dec;

  assign insn   = bus.in_insn;
  assign opcode = insn[6:0];
  assign f3     = insn[14:12];
  assign f7     = insn[31:25];
  assign is_w   = (opcode == OPC_OP32) || (opcode == OPC_OPIMM32);

  assign imm_i  = XLEN'($signed(insn[31:20]));
  assign imm_s  = XLEN'($signed({insn[31:25], insn[11:7]}));
  assign imm_b  = XLEN'($signed({insn[31], insn[7], insn[30:25], insn[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({insn[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({insn[31], insn[19:12], insn[20], insn[30:21], 1'b0}));
  assign imm_sh = RV32 ? XLEN'(insn[24:20]) : XLEN'(insn[25:20]);
  assign imm_z  = XLEN'(insn[19:15]);

`ifdef DECODE_RVM_EN
  assign f7_m = (f7 == 7'b0000001);
`else
  assign f7_m = 1'b0;
`endif

  // Legal funct7 for OP/OP-32: base, sub/sra, or M when compiled in.
  assign op_f7_ok = (f7 == 7'b0000000) ||
                    ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))) ||
                    f7_m;

  // Shift-immediate upper bits: 000000, or 010000 only for srai.
  assign shift_ok = ((insn[31:26] == 6'b000000) ||
                     ((insn[31:26] == 6'b010000) && (f3 == 3'b101))) &&
                    !(RV32 && insn[25]);

  // Decode of the offered instruction.
  always_comb begin
    cls = 4'd15;
    ill = 1'b0;
    dec = '0;
    dec.pc   = bus.in_pc;
    dec.insn = insn;
    dec.rd   = insn[11:7];
    dec.rs1  = insn[19:15];
    dec.rs2  = insn[24:20];
    dec.op   = {is_w, insn[30], insn[25], f3};
    case (opcode)
      OPC_OP: begin
        cls = 4'd0;
        ill = !op_f7_ok;
      end
      OPC_OP32: begin
        cls = 4'd0;
        ill = !op_f7_ok || (f7_m && (f3 != 3'b000) && !f3[2]) || RV32;
      end
      OPC_OPIMM, OPC_OPIMM32: begin
        cls     = 4'd1;
        dec.imm = imm_i;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec.imm = imm_sh;
          ill     = !shift_ok;
        end
        if (opcode == OPC_OPIMM32 && RV32) ill = 1'b1;
      end
      OPC_LOAD: begin
        cls     = 4'd2;
        dec.imm = imm_i;
        ill     = (f3 == 3'b111) || (RV32 && (f3 == 3'b011 || f3 == 3'b110));
      end
      OPC_STORE: begin
        cls     = 4'd3;
        dec.imm = imm_s;
        ill     = f3[2] || (RV32 && f3 == 3'b011);
      end
      OPC_BRANCH: begin
        cls     = 4'd4;
        dec.imm = imm_b;
        ill     = (f3[2:1] == 2'b01);
      end
      OPC_JAL: begin
        cls     = 4'd5;
        dec.imm = imm_j;
      end
      OPC_JALR: begin
        cls     = 4'd6;
        dec.imm = imm_i;
        ill     = (f3 != 3'b000);
      end
      OPC_LUI: begin
        cls     = 4'd7;
        dec.imm = imm_u;
      end
      OPC_AUIPC: begin
        cls     = 4'd8;
        dec.imm = imm_u;
      end
      OPC_SYSTEM: begin
        cls     = 4'd9;
        dec.imm = f3[2] ? imm_z : imm_i;
        ill     = (f3 == 3'b100);
      end
      default: ill = 1'b1;
    endcase
    if (insn[1:0] != 2'b11) ill = 1'b1;
    dec.illegal = ill;
    dec.cls     = ill ? 4'd15 : cls;
  end

  // Handshake; readiness depends only on the registered count.
  assign full          = (count == CW'(DEPTH));
  assign empty         = (count == '0);
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign push          = bus.in_valid && !full && !flush;
  assign pop           = !empty && bus.out_ready && !flush;

  // FIFO storage, pointers and statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cnt_decoded <= '0;
      cnt_illegal <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= dec;
          wr_ptr      <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop) count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end
      if (push) begin
        cnt_decoded <= cnt_decoded + 32'd1;
        if (dec.illegal && cnt_illegal != 16'hFFFF) cnt_illegal <= cnt_illegal + 16'd1;
      end
    end
  end

  assign bus.out_pc      = mem[rd_ptr].pc;
  assign bus.out_insn    = mem[rd_ptr].insn;
  assign bus.out_rd      = mem[rd_ptr].rd;
  assign bus.out_rs1     = mem[rd_ptr].rs1;
  assign bus.out_rs2     = mem[rd_ptr].rs2;
  assign bus.out_imm     = mem[rd_ptr].imm;
  assign bus.out_class   = mem[rd_ptr].cls;
  assign bus.out_op      = mem[rd_ptr].op;
  assign bus.out_illegal = mem[rd_ptr].illegal;
endmodule

// File: doc/rv_decode_stage.md
# rv_decode_stage

Synthesizable, parametrised RISC-V instruction decode stage for RV32IM/RV64IM. It accepts raw 32-bit instructions with their PC over a valid/ready handshake and decodes each into register indices, a sign-extended immediate, an operation class and an illegal flag. Decoded entries are buffered in an output FIFO for the execute stage. It sits between the fetch queue and the issue logic and replaces the simulation-only decode task; `$display` tracing is now the disassembler's job.

## Interface
- `XLEN`, 64: datapath width; legal values are 32 and 64.
- `DEPTH`, 4: output FIFO entries; must be a power of 2 and at least 2.
- `clk` input 1: the one clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous pipeline flush.
- `in_valid` input 1: instruction offered.
- `in_ready` output 1: instruction accepted when `in_valid && in_ready`.
- `in_insn` input 32: raw instruction.
- `in_pc` input 64: instruction PC.
- `out_valid` output 1: FIFO head valid.
- `out_ready` input 1: head consumed when `out_valid && out_ready`.
- `out_pc` output 64, `out_insn` output 32: passed through unchanged.
- `out_rd`, `out_rs1`, `out_rs2` output 5 each: register fields `insn[11:7]`, `[19:15]`, `[24:20]`.
- `out_imm` output XLEN: sign-extended immediate.
- `out_class` output 4: operation class.
- `out_op` output 6: `{is_w, insn[30], insn[25], funct3}`.
- `out_illegal` output 1: illegal or unsupported encoding.
- `cnt_decoded` output 32: count of accepted instructions.
- `cnt_illegal` output 16: count of accepted illegal instructions.

## Operation
- **Classes:**
  - 0 OP, 1 OP-IMM (including the W forms), 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 SYSTEM, 15 ILLEGAL.
  - `is_w` is 1 for opcodes 0111011 and 0011011.
- **Immediates:** standard I, S, B, U and J formats, sign-extended to XLEN.
  - Shifts: the immediate is the shamt, zero-extended; it is `insn[25:20]` on RV64 and `insn[24:20]` on RV32.
  - CSR immediate forms (funct3 1xx): the immediate is the uimm `insn[19:15]`, zero-extended.
  - R-type: the immediate is 0.
- **Illegal conditions:** on any of these, `out_illegal`=1 and class=15; the other fields are still decoded.
  - Unknown opcode, or `insn[1:0]` != 11.
  - OP: funct7 is not 0000000; or 0100000 with funct3 other than 000/101; or 0000001 (unless M is enabled).
  - OP-32: the same rules, plus M funct3 001/010/011 are illegal.
  - OP-32, OP-IMM-32, and loads/stores with funct3 011 or 110 (ld/lwu/sd) are illegal on `XLEN`=32.
  - LOAD funct3 111 is illegal. STORE funct3 1xx is illegal. BRANCH funct3 010/011 is illegal. JALR funct3 != 000 is illegal. SYSTEM funct3 100 is illegal.
  - Shift immediates: the upper bits must be 000000 or 010000 (srai only); on RV32, `insn[25]`=1 is illegal.
- **FIFO:** a push occurs on `in_valid && in_ready && !flush`. A pop occurs on `out_valid && out_ready && !flush`.
- **Counters:** increment on every push. `cnt_decoded` wraps. `cnt_illegal` saturates at 0xFFFF. Counters are not cleared by `flush`.

## Timing
- **Reset:** all pointers and counters are 0; `out_valid`=0; `in_ready`=1. All output data fields are 0 at reset.
- **Latency:** an instruction pushed at edge N is at the head with `out_valid`=1 after edge N, if the FIFO was empty. There is no combinational path from `in_*` to `out_*`.
- **Ready:** `in_ready` = !full, computed from registered count only. It is independent of `out_ready`.
  - When the FIFO is full, a simultaneous pop does not enable a push in the same cycle.
- **Push and pop together:** when not full and not empty, both happen and the count is unchanged.
- **Flush:**
  - At the edge, the FIFO empties; `out_valid`=0 and `in_ready`=1 on the next cycle.
  - The input offered in the flush cycle is dropped and not counted.
- **Pointer wrap:** pointers wrap modulo `DEPTH`; full/empty are derived from a count of width log2(DEPTH)+1.
- **Reset mid-operation:** asserting `rst_n`=0 immediately clears all state. Entries in flight are discarded.

## Configuration
- `DECODE_RVM_EN` defined: the M-extension encodings decode as legal, class 0, `out_op` bit3=1.
  - This covers OP funct7 0000001, and OP-32 funct7 0000001 with funct3 000/1xx.
- Undefined: all funct7=0000001 encodings are illegal (class 15, `cnt_illegal` increments). The M decode logic is not compiled in.

## Test plan
- **Reset/basic:** push 0x003100B3 (add x1,x2,x3) at PC 0x1000 with `out_ready`=1.
  - Next cycle: `out_valid`=1, class 0, rd=1, rs1=2, rs2=3, `out_op`=0, imm=0, `cnt_decoded`=1.
- **Immediates:** push 0xFFF10093 (addi x1,x2,-1), 0xFE209EE3 (bne x1,x2,-4) and 0x800000EF (jal x1,-1M).
  - `out_imm` must be 0xFFFF_FFFF_FFFF_FFFF, 0xFFFF_FFFF_FFFF_FFFC and 0xFFFF_FFFF_FFF0_0000 respectively.
- **Backpressure:** hold `out_ready`=0 and push DEPTH+2 instructions.
  - `in_ready` drops after DEPTH pushes; exactly DEPTH entries are accepted.
  - Then raise `out_ready`: entries drain in order with no duplicates.
- **Illegal/config:** push 0x023100B3 (mul), 0x0000707F (unknown opcode) and, with `XLEN`=32, 0x00013083 (ld).
  - mul decodes as legal only with `DECODE_RVM_EN`; the others are illegal.
  - `cnt_illegal` matches the number of illegal pushes.
- **Flush:** fill 3 entries, then assert `flush` together with `in_valid`.
  - Next cycle: `out_valid`=0, `in_ready`=1, and `cnt_decoded` is unchanged by the dropped input.
- **Counter saturation:** force `cnt_illegal` to 0xFFFE, then push 3 illegal instructions.
  - `cnt_illegal` must read 0xFFFF and stay there.
